traffic_phase_scheduler: RTL and testbench
==========================================

// Module: traffic_phase_scheduler
// PURPOSE
//   Four-approach intersection scheduler (N=0, E=1, S=2, W=3).
//   - Latches vehicle requests per approach.
//   - Grants green to one approach at a time, round-robin.
//   - Sequences GREEN -> YELLOW -> ALL_RED clearance with parameterised timers.
//   - Drives the per-approach lamp vectors. Sits above the lamp/sensor datapath.
// PARAMETERS
//   TW        8   timer width in bits; every timing parameter must be < 2**TW
//   MIN_GREEN 10  minimum green length in cycles (>=1)
//   MAX_GREEN 40  green length after which a pending conflict forces yellow (>=MIN_GREEN)
//   YELLOW_T  4   exact yellow length in cycles (>=1)
//   CLEAR_T   2   exact all-red clearance length in cycles (>=1)
// PORTS
//   clk    in   1  clock; all logic on posedge
//   res    in   1  reset, synchronous, active-high
//   en     in   1  advance enable; low freezes state, timer and pending bits
//   req    in   4  vehicle request per approach; level or pulse, sampled every edge
//   green  out  4  one-hot or zero; green lamp per approach
//   yellow out  4  one-hot or zero; yellow lamp per approach
//   red    out  4  red lamp per approach = ~(green|yellow)
//   phase  out  2  approach currently or last served
//   busy   out  1  high when state != IDLE
// BEHAVIOUR
//   Reset (res=1 at an edge)
//   - state=IDLE, timer=0, pend=0, last=3 (so the first grant goes to approach 0).
//   - Outputs: green=0, yellow=0, red=4'hF, phase=3, busy=0.
//   - Applies on the next edge regardless of state or en; reset mid-phase discards the phase.
//   Outputs are a Moore decode of registered state/last; no combinational path from req.
//   Pending: pend[i] <= (pend[i] | req[i]) & ~(i granted this edge) & ~(green[i]).
//   - Grant wins over a simultaneous set.
//   - A request from the approach already on green is dropped.
//   Round-robin pick
//   - Candidates c = pend | req.
//   - Winner = first set bit of c searching last+1, last+2, ... mod 4.
//   - On grant, last <= winner.
//   Timer: cleared on every state entry; increments each enabled cycle; saturates at 2**TW-1.
//   State machine (evaluated only when en=1; en=0 holds everything, lamps unchanged)
//   - IDLE
//     - All red.
//     - If c!=0: grant winner -> GREEN on that edge; green visible the next cycle.
//     - Otherwise stay.
//   - GREEN (approach=last); let oth = c & ~onehot(last)
//     - If timer>=MIN_GREEN-1 and oth!=0 -> YELLOW.
//     - MAX_GREEN caps extension: oth arriving with timer>=MAX_GREEN-1 exits at once.
//     - With oth==0, green rests indefinitely.
//     - Effective rule: exit when oth!=0 and timer>=MIN_GREEN-1.
//   - YELLOW: exit when timer==YELLOW_T-1 -> ALL_RED. Lasts exactly YELLOW_T enabled cycles.
//   - ALL_RED
//     - Exit when timer==CLEAR_T-1.
//     - If c!=0: grant winner -> GREEN.
//     - Otherwise -> IDLE.
//     - Same-approach re-grant is allowed if it is the only requester.
//   Invariant: at most one bit of green|yellow set. Never green on two approaches; never green without a prior ALL_RED or IDLE.
// STRUCTURE
//   Shared package traffic_pkg
//   - State encoding IDLE=2'd0, GREEN=2'd1, YELLOW=2'd2, ALL_RED=2'd3.
//   - Approach indices N/E/S/W.
//   - Lamp-vector width 4.
//   Sub-module rr_pick4: combinational round-robin picker.
//   - Inputs: 4-bit cand, 2-bit last.
//   - Outputs: 2-bit winner, 1-bit valid.
//   Top module holds: FSM, timer, pend register and lamp decode.
// TESTING (default parameters)
//   1. Reset, then req=4'b0100 for one cycle.
//      -> green=4'b0100 the cycle after sampling; phase=2; busy=1.
//   2. Only approach 0 requests and holds req[0]=1 for 100 cycles.
//      -> green=4'b0001 throughout; no yellow.
//   3. green[0] active; req[1] pulses at green cycle 3.
//      -> green[0] for 10 cycles total; yellow=4'b0001 for 4; red=4'hF for 2; then green=4'b0010.
//   4. After reset, req=4'hF held from IDLE.
//      -> greens in order 0,1,2,3,0; each separated by 4 yellow + 2 all-red cycles.
//   5. en=0 for 5 cycles in the middle of yellow.
//      -> yellow visible 9 cycles; timer frozen; pend unchanged.
//   6. res=1 at green cycle 5 with pend=4'b1010.
//      -> next cycle red=4'hF, busy=0, pend=0; first grant afterwards goes to approach 0.

Source files
------------

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared types and helpers for the intersection phase scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    localparam int c_LAMP_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2,
        ALL_RED = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        APP_N = 2'd0,
        APP_E = 2'd1,
        APP_S = 2'd2,
        APP_W = 2'd3
    } approach_t;

    function automatic logic [c_LAMP_W-1:0] approach_onehot(input logic [1:0] a);
        approach_onehot = c_LAMP_W'(1) << a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational 4-way round-robin picker; searches last+1 onward.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4 (
    input  logic [3:0] cand,
    input  logic [1:0] last,
    output logic [1:0] winner,
    output logic       valid
);

    // Walk from the farthest offset down so the nearest candidate after
    // 'last' overrides; offset 4 wraps to 'last' itself.
    always_comb begin
        winner = last;
        valid  = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            if (cand[2'(int'(last) + k)]) begin
                winner = 2'(int'(last) + k);
                valid  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_scheduler
// Description : Four-approach round-robin green/yellow/all-red phase sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int TW        = 8,
    parameter int MIN_GREEN = 10,
    parameter int MAX_GREEN = 40,
    parameter int YELLOW_T  = 4,
    parameter int CLEAR_T   = 2
) (
    input  logic                clk,
    input  logic                res,
    input  logic                en,
    input  logic [c_LAMP_W-1:0] req,
    output logic [c_LAMP_W-1:0] green,
    output logic [c_LAMP_W-1:0] yellow,
    output logic [c_LAMP_W-1:0] red,
    output logic [1:0]          phase,
    output logic                busy
);

    localparam logic [TW-1:0] c_MIN_LAST   = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] c_MAX_LAST   = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] c_YEL_LAST   = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] c_CLR_LAST   = TW'(CLEAR_T - 1);
    localparam logic [TW-1:0] c_TIMER_MAX  = '1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [TW-1:0]         r_timer;
    logic [c_LAMP_W-1:0]   r_pend;
    logic [c_LAMP_W-1:0]   w_pend_nxt;
    logic [1:0]            r_last;
    logic [1:0]            w_last_nxt;
    logic [c_LAMP_W-1:0]   w_cand;
    logic [c_LAMP_W-1:0]   w_oth;
    logic [c_LAMP_W-1:0]   w_green;
    logic [c_LAMP_W-1:0]   w_yellow;
    logic [c_LAMP_W-1:0]   w_grant_vec;
    logic                  w_grant;
    logic [1:0]            w_winner;
    logic                  w_valid;

    rr_pick4 u_pick (
        .cand   (w_cand),
        .last   (r_last),
        .winner (w_winner),
        .valid  (w_valid)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_pend  <= '0;
            r_last  <= APP_W;
        end else if (en) begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_pend  <= w_pend_nxt;
            if (w_state_nxt != r_state) begin
                r_timer <= '0;
            end else if (r_timer != c_TIMER_MAX) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    always_comb begin
        w_cand      = r_pend | req;
        w_oth       = w_cand & ~approach_onehot(r_last);
        w_green     = (r_state == GREEN)  ? approach_onehot(r_last) : '0;
        w_yellow    = (r_state == YELLOW) ? approach_onehot(r_last) : '0;
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_grant     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_state_nxt = GREEN;
                    w_last_nxt  = w_winner;
                    w_grant     = 1'b1;
                end
            end
            GREEN: begin
                // MAX_GREEN >= MIN_GREEN, so the cap never delays an exit.
                if ((w_oth != '0) &&
                    ((r_timer >= c_MIN_LAST) || (r_timer >= c_MAX_LAST))) begin
                    w_state_nxt = YELLOW;
                end
            end
            YELLOW: begin
                if (r_timer == c_YEL_LAST) begin
                    w_state_nxt = ALL_RED;
                end
            end
            ALL_RED: begin
                if (r_timer == c_CLR_LAST) begin
                    if (w_valid) begin
                        w_state_nxt = GREEN;
                        w_last_nxt  = w_winner;
                        w_grant     = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // A grant clears its own request even if it re-asserts on the same edge.
        w_grant_vec = w_grant ? approach_onehot(w_winner) : '0;
        w_pend_nxt  = w_cand & ~w_grant_vec & ~w_green;
    end

    assign green  = w_green;
    assign yellow = w_yellow;
    assign red    = ~(w_green | w_yellow);
    assign phase  = r_last;
    assign busy   = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_phase_scheduler
// Description : Segment scoreboard for the phase scheduler: each run of
//               constant lamp/phase/busy outputs is matched against a queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_scheduler;

    typedef struct packed {
        logic [14:0] pat;
        int          len;
    } seg_t;

    logic       clk;
    logic       res;
    logic       en;
    logic [3:0] req;
    logic [3:0] green;
    logic [3:0] yellow;
    logic [3:0] red;
    logic [1:0] phase;
    logic       busy;

    seg_t        exp_q[$];
    int          checks;
    int          errors;
    int          seg_no;
    logic        mon_on;
    logic        have_seg;
    logic [14:0] seg_pat;
    int          seg_len;

    traffic_phase_scheduler #(
        .TW        (8),
        .MIN_GREEN (10),
        .MAX_GREEN (40),
        .YELLOW_T  (4),
        .CLEAR_T   (2)
    ) dut (
        .clk    (clk),
        .res    (res),
        .en     (en),
        .req    (req),
        .green  (green),
        .yellow (yellow),
        .red    (red),
        .phase  (phase),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] mk(input logic [3:0] g, input logic [3:0] y,
                                       input logic [1:0] ph, input logic b);
        mk = {g, y, ~(g | y), ph, b};
    endfunction

    function automatic logic [14:0] seg_rst();
        seg_rst = mk(4'h0, 4'h0, 2'd3, 1'b0);
    endfunction

    function automatic logic [14:0] seg_g(input int a);
        seg_g = mk(4'(1 << a), 4'h0, 2'(a), 1'b1);
    endfunction

    function automatic logic [14:0] seg_y(input int a);
        seg_y = mk(4'h0, 4'(1 << a), 2'(a), 1'b1);
    endfunction

    function automatic logic [14:0] seg_ar(input int a);
        seg_ar = mk(4'h0, 4'h0, 2'(a), 1'b1);
    endfunction

    task automatic push(input logic [14:0] p, input int n);
        seg_t s;
        s.pat = p;
        s.len = n;
        exp_q.push_back(s);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic close_seg(input logic [14:0] p, input int n);
        seg_t e;
        checks = checks + 1;
        if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL seg%0d unexpected: actual pat=%h len=%0d required none",
                     seg_no, p, n);
        end else begin
            e = exp_q.pop_front();
            if (p !== e.pat || n != e.len) begin
                errors = errors + 1;
                $display("FAIL seg%0d: actual pat=%h len=%0d required pat=%h len=%0d",
                         seg_no, p, n, e.pat, e.len);
            end
        end
        seg_no = seg_no + 1;
    endtask

    // Monitor: accumulate runs of identical outputs, score each run when it ends.
    always @(negedge clk) begin
        if (mon_on) begin
            checks = checks + 1;
            if ($countones(green | yellow) > 1) begin
                errors = errors + 1;
                $display("FAIL onehot t=%0t: actual green=%b yellow=%b required at most one lamp",
                         $time, green, yellow);
            end
            if (!have_seg) begin
                have_seg = 1'b1;
                seg_pat  = {green, yellow, red, phase, busy};
                seg_len  = 1;
            end else if ({green, yellow, red, phase, busy} !== seg_pat) begin
                close_seg(seg_pat, seg_len);
                seg_pat = {green, yellow, red, phase, busy};
                seg_len = 1;
            end else begin
                seg_len = seg_len + 1;
            end
        end
    end

    initial begin
        checks   = 0;
        errors   = 0;
        seg_no   = 0;
        mon_on   = 1'b0;
        have_seg = 1'b0;
        seg_pat  = '0;
        seg_len  = 0;
        res      = 1'b1;
        en       = 1'b1;
        req      = 4'h0;

        tick(1);
        mon_on = 1'b1;
        res    = 1'b0;

        // Single pulse from approach 2 out of reset.
        push(seg_rst(), 3);
        tick(2);
        req = 4'b0100;
        tick(1);
        req = 4'h0;
        push(seg_g(2), 10);
        tick(9);
        res = 1'b1;
        tick(1);
        res = 1'b0;

        // Approach 0 alone holds its request: green rests.
        push(seg_rst(), 1);
        req = 4'b0001;
        tick(1);
        push(seg_g(0), 100);
        tick(99);
        res = 1'b1;
        req = 4'h0;
        tick(1);
        res = 1'b0;

        // Conflict at green cycle 3 from approach 1.
        push(seg_rst(), 1);
        req = 4'b0001;
        tick(1);
        req = 4'h0;
        push(seg_g(0), 10);
        push(seg_y(0), 4);
        push(seg_ar(0), 2);
        push(seg_g(1), 18);
        tick(2);
        req = 4'b0010;
        tick(1);
        req = 4'h0;

        // Conflict from approach 2, then freeze five cycles inside yellow.
        tick(30);
        req = 4'b0100;
        tick(1);
        req = 4'h0;
        push(seg_y(1), 9);
        push(seg_ar(1), 2);
        push(seg_g(2), 12);
        tick(1);
        en = 1'b0;
        tick(2);
        req = 4'b1000;
        tick(1);
        req = 4'h0;
        tick(2);
        en = 1'b1;
        tick(16);
        res = 1'b1;
        tick(1);
        res = 1'b0;

        // Reset at green cycle 5 with pending 1010.
        push(seg_rst(), 1);
        req = 4'b0001;
        tick(1);
        req = 4'h0;
        push(seg_g(0), 5);
        tick(1);
        req = 4'b1010;
        tick(1);
        req = 4'h0;
        tick(2);
        res = 1'b1;
        tick(1);
        res = 1'b0;
        push(seg_rst(), 5);
        tick(4);
        req = 4'b0001;
        tick(1);
        req = 4'h0;
        push(seg_g(0), 5);
        tick(4);
        res = 1'b1;
        tick(1);
        res = 1'b0;

        // All four approaches requesting from IDLE.
        push(seg_rst(), 1);
        req = 4'hF;
        for (int a = 0; a < 4; a++) begin
            push(seg_g(a), 10);
            push(seg_y(a), 4);
            push(seg_ar(a), 2);
        end
        push(seg_g(0), 4);
        tick(68);
        res = 1'b1;
        req = 4'h0;
        tick(1);
        res = 1'b0;
        push(seg_rst(), 3);
        tick(2);
        req = 4'b0001;
        tick(1);
        req = 4'h0;
        tick(3);

        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: actual %0d segments unseen, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
